shift_regn: RTL and testbench
=============================

SHIFT_REGN -- requirements
Module: shift_regn

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width in bits of each word.
REQ-002 Parameter NUM_SHIFTS, default 32, number of register stages (stage 0 = input end, stage NUM_SHIFTS-1 = last).
REQ-003 Parameter NUM_TAPS, default 4, number of intermediate taps, excluding the last-stage output.
REQ-004 Parameter TAP_START, default 0, stage index of the first tap.
REQ-005 Parameter TAPS_STRIDE, default 8, stage distance between consecutive taps.
REQ-006 Parameter NUM_TOTAL_OUT, default 1+NUM_TAPS, number of output words.
REQ-007 sr_clk  input  1  single clock; all state updates on its rising edge.
REQ-008 sr_rst_b  input  1  reset; asynchronous, active-low.
REQ-009 sr_en  input  1  shift enable; active-high.
REQ-010 sr_data_i  input  DATA_WIDTH  word shifted into stage 0.
REQ-011 sr_data_o  output  packed [NUM_TOTAL_OUT-1:0][DATA_WIDTH-1:0]  last-stage word plus tap words.

Function
REQ-012 The block SHALL hold NUM_SHIFTS registers of DATA_WIDTH bits each, stage[0..NUM_SHIFTS-1].
REQ-013 On a rising sr_clk edge with sr_en=1 and sr_rst_b=1: stage[0] SHALL load sr_data_i, and each stage[k] SHALL load the old stage[k-1] for k>=1.
REQ-014 With sr_en=0, all stages SHALL hold their value; the block SHALL drop no data and insert no data.
REQ-015 sr_data_o[0] SHALL be stage[NUM_SHIFTS-1], the last stage.
REQ-016 sr_data_o[1+i] SHALL be stage[TAP_START + i*TAPS_STRIDE] for i = 0..NUM_TAPS-1; with the defaults, the taps are stages 0, 8, 16 and 24.
REQ-017 Outputs SHALL be driven combinationally from the stage registers, with no extra output register.
REQ-018 Latency: a word sampled at enabled edge n SHALL appear on tap i after that edge plus TAP_START+i*TAPS_STRIDE further enabled edges, and on sr_data_o[0] after NUM_SHIFTS enabled edges total. Disabled edges SHALL not count.
REQ-019 Elaboration SHALL fail with an error unless all of the following hold: NUM_SHIFTS>=1; NUM_TAPS>=1; NUM_TOTAL_OUT==1+NUM_TAPS; TAPS_STRIDE>=1; TAP_START+(NUM_TAPS-1)*TAPS_STRIDE <= NUM_SHIFTS-1.
REQ-020 Taps and the last stage MAY reference the same stage; each output SHALL still show that stage's value.

Reset
REQ-021 When sr_rst_b=0, all stages SHALL clear to 0 immediately, without waiting for a clock edge, so every sr_data_o word reads 0.
REQ-022 Reset SHALL override sr_en; while sr_rst_b=0, shifting SHALL be inhibited.
REQ-023 Reset asserted mid-stream SHALL discard all stored data. After sr_rst_b returns to 1, shifting SHALL resume from an all-zero pipeline on the next enabled edge.

Structure
REQ-024 A shared package shift_regn_pkg SHALL hold the default parameter constants and a function computing a tap's stage index: TAP_START+i*TAPS_STRIDE.
REQ-025 The pipeline SHALL be one packed-array register in a single always_ff block, with tap selection in generate logic.
REQ-026 No sub-module is required. An optional sub-module sr_stage (one enabled, resettable DATA_WIDTH register) MAY be used per stage.

Verification
REQ-027 Reset, then sr_en=1, then drive 0x11111111 for one cycle -> next cycle sr_data_o[1]=0x11111111 and all other words 0.
REQ-028 Drive 0x11111111, 0x22222222, ... on consecutive enabled edges -> after 9 edges sr_data_o[2] (stage 8)=0x11111111; after 32 edges sr_data_o[0]=0x11111111 and sr_data_o[4] (stage 24)=0x88888888.
REQ-029 Mid-stream, hold sr_en=0 for 6 cycles while sr_data_i changes -> all outputs unchanged; when sr_en is re-asserted, shifting continues from the held state.
REQ-030 Assert sr_rst_b=0 between clock edges -> all outputs read 0 before the next edge; release it and drive 0x11111111, 0x22222222, 0x33333333 -> sr_data_o[1]=0x33333333 and sr_data_o[2]=0.
REQ-031 Parameter sweep with NUM_SHIFTS=5, NUM_TAPS=2, TAP_START=1, TAPS_STRIDE=3 -> taps at stages 1 and 4, with stage 4 equal to sr_data_o[0]; an illegal setting such as TAP_START=3 SHALL fail elaboration.

Source files
------------

// File: rtl/shift_regn_pkg.sv
// rtl/shift_regn_pkg.sv - shared defaults and tap index helper for shift_regn
// Purpose: default parameter constants and the tap-to-stage mapping used by
//          shift_regn and anything that needs to know where its taps sit.
// Ports:   none (package)
package shift_regn_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_NUM_SHIFTS  = 32;
   localparam int DEF_NUM_TAPS    = 4;
   localparam int DEF_TAP_START   = 0;
   localparam int DEF_TAPS_STRIDE = 8;

   // Stage index observed by intermediate tap i.
   function automatic int tap_stage(input int tap_start, input int taps_stride, input int i);
      return tap_start + i * taps_stride;
   endfunction

endpackage

// File: rtl/shift_regn.sv
// rtl/shift_regn.sv - enabled multi-word shift register with stride taps
// Purpose: NUM_SHIFTS-deep pipeline of DATA_WIDTH words that advances one
//          stage per enabled clock; exposes the last stage and NUM_TAPS
//          evenly spaced intermediate stages.
// Ports:
//   sr_clk     in   clock, rising edge
//   sr_rst_b   in   asynchronous active-low reset, clears every stage
//   sr_en      in   shift enable
//   sr_data_i  in   word loaded into stage 0
//   sr_data_o  out  [0] = last stage, [1+i] = stage TAP_START+i*TAPS_STRIDE
module shift_regn
   import shift_regn_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int NUM_SHIFTS    = DEF_NUM_SHIFTS,
   parameter int NUM_TAPS      = DEF_NUM_TAPS,
   parameter int TAP_START     = DEF_TAP_START,
   parameter int TAPS_STRIDE   = DEF_TAPS_STRIDE,
   parameter int NUM_TOTAL_OUT = 1 + NUM_TAPS
) (
   input  logic                                      sr_clk,
   input  logic                                      sr_rst_b,
   input  logic                                      sr_en,
   input  logic [DATA_WIDTH-1:0]                     sr_data_i,
   output logic [NUM_TOTAL_OUT-1:0][DATA_WIDTH-1:0]  sr_data_o
);

   // Reject parameter sets whose taps would fall outside the pipeline.
   if (!(NUM_SHIFTS >= 1 && NUM_TAPS >= 1 && NUM_TOTAL_OUT == 1 + NUM_TAPS &&
         TAPS_STRIDE >= 1 &&
         TAP_START + (NUM_TAPS - 1) * TAPS_STRIDE <= NUM_SHIFTS - 1)) begin : g_param_check
      $error("shift_regn: illegal parameters NUM_SHIFTS=%0d NUM_TAPS=%0d NUM_TOTAL_OUT=%0d TAP_START=%0d TAPS_STRIDE=%0d",
             NUM_SHIFTS, NUM_TAPS, NUM_TOTAL_OUT, TAP_START, TAPS_STRIDE);
   end

   logic [NUM_SHIFTS-1:0][DATA_WIDTH-1:0] stage;

   // Per-stage copy loop rather than a concatenation so NUM_SHIFTS=1 needs
   // no special-cased slice.
   always_ff @(posedge sr_clk or negedge sr_rst_b) begin
      if (!sr_rst_b) begin
         stage <= '0;
      end else if (sr_en) begin
         stage[0] <= sr_data_i;
         for (int k = 1; k < NUM_SHIFTS; k++) begin
            stage[k] <= stage[k-1];
         end
      end
   end

   assign sr_data_o[0] = stage[NUM_SHIFTS-1];

   for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
      localparam int TAP_IDX = tap_stage(TAP_START, TAPS_STRIDE, i);
      assign sr_data_o[1+i] = stage[TAP_IDX];
   end

endmodule

// File: tb/tb_shift_regn.sv
// tb/tb_shift_regn.sv - scoreboard bench for shift_regn (default and small configs)
module tb_shift_regn;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        en;
   logic [31:0] din;
   logic [4:0][31:0] out_a;
   logic [2:0][31:0] out_b;

   always #5 clk = ~clk;

   shift_regn dut_a (
      .sr_clk    (clk),
      .sr_rst_b  (rst_b),
      .sr_en     (en),
      .sr_data_i (din),
      .sr_data_o (out_a)
   );

   shift_regn #(
      .DATA_WIDTH    (32),
      .NUM_SHIFTS    (5),
      .NUM_TAPS      (2),
      .TAP_START     (1),
      .TAPS_STRIDE   (3),
      .NUM_TOTAL_OUT (3)
   ) dut_b (
      .sr_clk    (clk),
      .sr_rst_b  (rst_b),
      .sr_en     (en),
      .sr_data_i (din),
      .sr_data_o (out_b)
   );

   typedef struct {
      logic [4:0][31:0] a;
      logic [2:0][31:0] b;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] hist[$];   // hist[k] = word accepted k enabled edges ago
   int          checks   = 0;
   int          failures = 0;

   function automatic logic [31:0] word_at(input int k);
      return (k < hist.size()) ? hist[k] : 32'h0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.a[0] = word_at(31);
      for (int i = 0; i < 4; i++) e.a[1+i] = word_at(8 * i);
      e.b[0] = word_at(4);
      for (int i = 0; i < 2; i++) e.b[1+i] = word_at(1 + 3 * i);
      sb.push_back(e);
   endtask

   task automatic step(input logic e, input logic [31:0] d);
      en  = e;
      din = d;
      @(posedge clk);
      #1;
      if (rst_b && e) begin
         hist.push_front(d);
         if (hist.size() > 32) void'(hist.pop_back());
      end
      push_exp();
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 5; i++) check($sformatf("%s_a[%0d]", tag, i), out_a[i], 32'h0);
      for (int i = 0; i < 3; i++) check($sformatf("%s_b[%0d]", tag, i), out_b[i], 32'h0);
   endtask

   // Monitor: every negedge following a stimulus edge has one expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < 5; i++) check($sformatf("sb_a[%0d]", i), out_a[i], e.a[i]);
            for (int i = 0; i < 3; i++) check($sformatf("sb_b[%0d]", i), out_b[i], e.b[i]);
         end
      end
   end

   initial begin
      int n;
      rst_b = 1'b0;
      en    = 1'b1;
      din   = 32'hdead_beef;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_b = 1'b1;

      // Incrementing pattern: word n = n * 0x11111111
      for (int k = 1; k <= 32; k++) begin
         step(1'b1, 32'h1111_1111 * k);
         if (k == 1) begin
            check("first_tap0", out_a[1], 32'h1111_1111);
            check("first_tap1", out_a[2], 32'h0);
            check("first_last", out_a[0], 32'h0);
         end
         if (k == 9) check("stage8_after9", out_a[2], 32'h1111_1111);
      end
      check("last_after32", out_a[0], 32'h1111_1111);
      check("stage24_after32", out_a[4], 32'h8888_8888);

      // Enable held low while data changes
      for (int k = 0; k < 6; k++) step(1'b0, $urandom);
      for (int k = 0; k < 10; k++) step(1'b1, $urandom);

      // Randomised enable and data
      for (int k = 0; k < 300; k++) step($urandom_range(0, 3) != 0, $urandom);

      // Asynchronous reset between edges
      @(negedge clk);
      #2;
      rst_b = 1'b0;
      #1;
      check_all_zero("async_rst");
      hist.delete();
      step(1'b1, 32'hcafe_f00d);
      rst_b = 1'b1;
      step(1'b1, 32'h1111_1111);
      step(1'b1, 32'h2222_2222);
      step(1'b1, 32'h3333_3333);
      check("post_rst_tap0", out_a[1], 32'h3333_3333);
      check("post_rst_tap1", out_a[2], 32'h0);
      check("post_rst_b_tap0", out_b[1], 32'h2222_2222);

      for (int k = 0; k < 200; k++) step($urandom_range(0, 1) != 0, $urandom);

      n = 0;
      while (sb.size() > 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
